// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus multi-cycle shift-add MUL and
// N-bit shifts/rotate behind a valid/ready handshake with abort.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             use_carry,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             sc_o,
  output logic             zero,
  output logic             pari,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic {IDLE, RUN} state_t;
  // Encoding matches alu_cmd[1:0] of the 10xx multi-cycle opcodes.
  typedef enum logic [1:0] {K_MUL, K_SLL, K_SRL, K_ROL} kind_t;

  state_t           state, state_nxt;
  kind_t            kind;
  logic [WIDTH-1:0] mcand, work_lo, work_hi;
  logic [CW-1:0]    cnt;

  logic             accept, is_mul, is_shn, start_multi, last_step;
  logic             commit_single, commit_multi, commit;
  logic [SHW-1:0]   n_amt;
  logic             cin;

  assign accept        = in_valid & in_ready;
  assign n_amt         = inB[SHW-1:0];
  assign cin           = use_carry & sc_o;
  assign is_mul        = MUL_EN && (alu_cmd == 4'b1000);
  assign is_shn        = (alu_cmd[3:2] == 2'b10) && (alu_cmd[1:0] != 2'b00);
  assign start_multi   = accept && (is_mul || (is_shn && (n_amt != '0)));
  assign last_step     = (state == RUN) && (cnt == CW'(1));
  assign commit_single = accept && !start_multi;
  assign commit_multi  = last_step && !abort;
  assign commit        = commit_single | commit_multi;

  // Single-cycle ops, evaluated on the accept edge.
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] sc_rslt;
  logic             sc_sc;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    arith   = '0;
    sc_rslt = inA;
    sc_sc   = sc_o;
    case (alu_cmd)
      4'b0000: begin
        arith            = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, cin};
        {sc_sc, sc_rslt} = arith;
      end
      4'b0001: {sc_sc, sc_rslt} = {inA, cin};
      4'b0010: {sc_rslt, sc_sc} = {cin, inA};
      4'b0011: sc_rslt = inA ^ inB;
      4'b0100: sc_rslt = inA & inB;
      4'b0101: sc_rslt = inA | inB;
      4'b0110: begin
        arith   = {1'b0, inA} - {1'b0, inB} - {{WIDTH{1'b0}}, cin};
        sc_rslt = arith[WIDTH-1:0];
        sc_sc   = arith[WIDTH];
      end
      default: ; // PASSA, reserved codes and zero-length shifts
    endcase
  end

  // One step of the running multi-cycle op.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_lo, step_hi;
  logic             step_sc;

  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
    step_hi = '0;
    step_lo = work_lo;
    step_sc = sc_o;
    case (kind)
      K_MUL: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        step_sc = |mul_sum[WIDTH:1];
      end
      K_SLL: begin
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
        step_sc = work_lo[WIDTH-1];
      end
      K_SRL: begin
        step_lo = {1'b0, work_lo[WIDTH-1:1]};
        step_sc = work_lo[0];
      end
      K_ROL: step_lo = {work_lo[WIDTH-2:0], work_lo[WIDTH-1]};
      default: ;
    endcase
  end

  logic [WIDTH-1:0] c_rslt, c_hi;
  logic             c_sc;

  assign c_rslt = commit_multi ? step_lo : sc_rslt;
  assign c_hi   = commit_multi ? step_hi : '0;
  assign c_sc   = commit_multi ? step_sc : sc_sc;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state; abort takes priority over the last step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_multi) state_nxt = RUN;
      RUN:     if (abort || last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      rslt      <= '0;
      rslt_hi   <= '0;
      sc_o      <= 1'b0;
      zero      <= 1'b0;
      pari      <= 1'b0;
      kind      <= K_MUL;
      mcand     <= '0;
      work_lo   <= '0;
      work_hi   <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= commit;
      if (commit) begin
        rslt    <= c_rslt;
        rslt_hi <= c_hi;
        sc_o    <= c_sc;
        zero    <= (c_rslt == '0);
        pari    <= ^c_rslt;
      end
      if (start_multi) begin
        kind    <= kind_t'(alu_cmd[1:0]);
        mcand   <= inA;
        work_lo <= is_mul ? inB : inA;
        work_hi <= '0;
        cnt     <= is_mul ? CW'(WIDTH) : CW'(n_amt);
      end else if (state == RUN) begin
        work_lo <= step_lo;
        work_hi <= step_hi;
        cnt     <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: WIDTH=8 instance for the full op set,
// WIDTH=16 instance for MUL latency and product.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, use_carry, abort, out_valid, sc_o, zero, pari, busy;
  logic [3:0] alu_cmd;
  logic [7:0] inA, inB, rslt, rslt_hi;

  logic        v16, rdy16, ov16, sc16, z16, p16, busy16;
  logic [3:0]  cmd16;
  logic [15:0] a16, b16, r16, h16;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .use_carry(use_carry), .abort(abort),
    .out_valid(out_valid), .rslt(rslt), .rslt_hi(rslt_hi), .sc_o(sc_o),
    .zero(zero), .pari(pari), .busy(busy)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
    .alu_cmd(cmd16), .inA(a16), .inB(b16), .use_carry(1'b0), .abort(1'b0),
    .out_valid(ov16), .rslt(r16), .rslt_hi(h16), .sc_o(sc16),
    .zero(z16), .pari(p16), .busy(busy16)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] hi;
    logic       sc;
    logic       z;
    logic       p;
  } exp_t;

  exp_t sb[$];
  exp_t last_out;
  logic m_sc;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for WIDTH=8.
  function automatic exp_t model(input logic [3:0] c, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin, input logic sc_prev);
    exp_t        e;
    logic [8:0]  t;
    logic [15:0] p;
    int          n;
    n    = int'(b[2:0]);
    e    = '0;
    e.r  = a;
    e.sc = sc_prev;
    case (c)
      4'b0000: begin t = {1'b0, a} + {1'b0, b} + {8'd0, cin}; {e.sc, e.r} = t; end
      4'b0001: {e.sc, e.r} = {a, cin};
      4'b0010: {e.r, e.sc} = {cin, a};
      4'b0011: e.r = a ^ b;
      4'b0100: e.r = a & b;
      4'b0101: e.r = a | b;
      4'b0110: begin t = {1'b0, a} - {1'b0, b} - {8'd0, cin}; e.r = t[7:0]; e.sc = t[8]; end
      4'b1000: begin p = 16'(a) * 16'(b); e.r = p[7:0]; e.hi = p[15:8]; e.sc = |p[15:8]; end
      4'b1001: if (n > 0) begin e.r = a << n; e.sc = a[8-n]; end
      4'b1010: if (n > 0) begin e.r = a >> n; e.sc = a[n-1]; end
      4'b1011: e.r = (a << n) | (a >> (8 - n));
      default: ;
    endcase
    e.z = (e.r == 8'h00);
    e.p = ^e.r;
    return e;
  endfunction

  task automatic step(input bit exp_ov);
    exp_t e;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (out_valid) begin
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rslt",    32'(rslt),    32'(e.r));
        check("rslt_hi", 32'(rslt_hi), 32'(e.hi));
        check("sc_o",    32'(sc_o),    32'(e.sc));
        check("zero",    32'(zero),    32'(e.z));
        check("pari",    32'(pari),    32'(e.p));
        last_out = e;
      end
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic uc, input bit push, input bit exp_ov);
    exp_t e;
    in_valid  = 1'b1;
    alu_cmd   = c;
    inA       = a;
    inB       = b;
    use_carry = uc;
    if (push) begin
      e = model(c, a, b, uc ? m_sc : 1'b0, m_sc);
      sb.push_back(e);
      m_sc = e.sc;
    end
    step(exp_ov);
    // Operands are latched on accept; scramble them to prove it.
    in_valid = 1'b0;
    inA      = 8'($urandom);
    inB      = 8'($urandom);
    alu_cmd  = 4'($urandom);
  endtask

  task automatic finish_multi(input int k);
    for (int i = 1; i < k; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_rslt"}, 32'(rslt),    32'(last_out.r));
    check({tag, "_hi"},   32'(rslt_hi), 32'(last_out.hi));
    check({tag, "_sc"},   32'(sc_o),    32'(last_out.sc));
    check({tag, "_zero"}, 32'(zero),    32'(last_out.z));
    check({tag, "_pari"}, 32'(pari),    32'(last_out.p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p16;
    int          lat;

    reset = 1'b1; in_valid = 1'b0; alu_cmd = '0; inA = '0; inB = '0;
    use_carry = 1'b0; abort = 1'b0;
    v16 = 1'b0; cmd16 = '0; a16 = '0; b16 = '0;
    m_sc = 1'b0; last_out = '0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check_held("rst");
    reset = 1'b0;

    // Back-to-back single-cycle ops
    issue(4'b0000, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b1);
    check("add_rslt", 32'(rslt), 32'h10);
    check("b2b_ready", 32'(in_ready), 32'd1);
    issue(4'b0000, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1);
    issue(4'b0110, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
    issue(4'b0100, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1);
    issue(4'b0011, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1);
    issue(4'b0101, 8'h12, 8'h40, 1'b0, 1'b1, 1'b1);
    issue(4'b0001, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1);
    issue(4'b0010, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1);
    issue(4'b0110, 8'h50, 8'h20, 1'b1, 1'b1, 1'b1);
    issue(4'b0111, 8'h77, 8'h11, 1'b0, 1'b1, 1'b1);
    issue(4'b1101, 8'h3E, 8'h99, 1'b0, 1'b1, 1'b1);
    step(1'b0);

    // MUL FF*FF: busy for 8 cycles, a request mid-run is ignored
    issue(4'b1000, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("mul_in_ready", 32'(in_ready), 32'd0);
      check("mul_busy",     32'(busy),     32'd1);
      if (i == 3) begin in_valid = 1'b1; alu_cmd = 4'b0000; inA = 8'h01; inB = 8'h01; end
      step(i == 7);
      in_valid = 1'b0;
    end
    check("mul_lo", 32'(rslt), 32'h01);
    check("mul_hi", 32'(rslt_hi), 32'hFE);
    check("mul_done_ready", 32'(in_ready), 32'd1);
    step(1'b0);

    // N-bit shifts and rotate
    issue(4'b1010, 8'h81, 8'h03, 1'b0, 1'b1, 1'b0);
    finish_multi(3);
    check("srln_rslt", 32'(rslt), 32'h10);
    issue(4'b1011, 8'h81, 8'h01, 1'b0, 1'b1, 1'b0);
    finish_multi(1);
    issue(4'b1001, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1);
    issue(4'b1001, 8'hC3, 8'h02, 1'b0, 1'b1, 1'b0);
    finish_multi(2);
    issue(4'b1011, 8'h96, 8'h07, 1'b0, 1'b1, 1'b0);
    finish_multi(7);
    issue(4'b1000, 8'h0D, 8'h0B, 1'b0, 1'b1, 1'b0);
    finish_multi(8);

    // Abort on step 4 of a MUL: no out_valid, outputs hold
    issue(4'b1000, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0);
    abort = 1'b1;
    step(1'b0);
    abort = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy",  32'(busy),     32'd0);
    check_held("abort");
    step(1'b0);
    issue(4'b0000, 8'h22, 8'h11, 1'b0, 1'b1, 1'b1);

    // Abort coinciding with the last step wins
    issue(4'b1010, 8'hF0, 8'h01, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    step(1'b0);
    abort = 1'b0;
    check("abort_last_ready", 32'(in_ready), 32'd1);
    check_held("abort_last");
    step(1'b0);

    // Abort while idle has no effect on an accepted op
    abort = 1'b1;
    issue(4'b0000, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b1);
    abort = 1'b0;

    // Asynchronous reset mid-MUL
    issue(4'b1000, 8'hFF, 8'h02, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0);
    #2 reset = 1'b1;
    #1;
    m_sc = 1'b0;
    last_out = '0;
    check("amid_out_valid", 32'(out_valid), 32'd0);
    check("amid_in_ready",  32'(in_ready),  32'd1);
    check("amid_busy",      32'(busy),      32'd0);
    check_held("amid");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    issue(4'b0000, 8'h7F, 8'h01, 1'b1, 1'b1, 1'b1);

    // WIDTH=16 MUL latency and product
    @(negedge clk);
    v16 = 1'b1; cmd16 = 4'b1000; a16 = 16'hFFFF; b16 = 16'hFFFF;
    p16 = 32'(a16) * 32'(b16);
    @(negedge clk);
    v16 = 1'b0; a16 = 16'h1234; b16 = 16'h0003;
    lat = 0;
    while (!ov16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w16_latency", 32'(lat), 32'd16);
    check("w16_lo", 32'(r16), 32'(p16[15:0]));
    check("w16_hi", 32'(h16), 32'(p16[31:16]));
    check("w16_sc", 32'(sc16), 32'(|p16[31:16]));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
